// File: rtl/gen_write_controller.sv
// Burst write controller: seeds a pattern generator, meters its generate strobes against
// downstream FIFO headroom, and counts the words that actually reach the FIFO.
`timescale 1ns/1ps
module gen_write_controller #(
    parameter int COUNT_W = 32,
    parameter int PAT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [PAT_W-1:0]   pattern_in,
    input  logic [COUNT_W-1:0] word_count,
    input  logic               fifo_prog_full,
    input  logic               fifo_full,
    input  logic               gen_valid,
    output logic [PAT_W-1:0]   gen_pattern,
    output logic               gen_reset,
    output logic               gen_enable,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] words_written,
    output logic               overflow_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEED   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t             state_q;
    logic [PAT_W-1:0]   pattern_q;
    logic [COUNT_W-1:0] remaining_q;
    logic [COUNT_W-1:0] remaining_d;
    logic [COUNT_W-1:0] words_q;
    logic               gen_reset_q;
    logic               gen_enable_q;
    logic               busy_q;
    logic               done_q;
    logic               overflow_q;

    // Words still owed once the strobe issued this cycle is accounted for; the strobe is
    // only ever raised while this is non-zero, so it cannot underflow.
    always_comb begin
        remaining_d = remaining_q - {{(COUNT_W-1){1'b0}}, gen_enable_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pattern_q    <= '0;
            remaining_q  <= '0;
            words_q      <= '0;
            gen_reset_q  <= 1'b1;
            gen_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            gen_reset_q  <= 1'b0;
            gen_enable_q <= 1'b0;
            done_q       <= 1'b0;
            if (gen_valid && fifo_full) begin
                overflow_q <= 1'b1;
            end
            if (gen_valid && state_q != S_IDLE) begin
                words_q <= words_q + 1'b1;
            end

            if (abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q     <= S_SEED;
                            busy_q      <= 1'b1;
                            pattern_q   <= pattern_in;
                            remaining_q <= word_count;
                            words_q     <= '0;
                            gen_reset_q <= 1'b1;
                            overflow_q  <= gen_valid && fifo_full;
                        end
                    end
                    S_SEED: begin
                        if (remaining_q == '0) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= S_RUN;
                            gen_enable_q <= !fifo_prog_full;
                        end
                    end
                    S_RUN: begin
                        remaining_q <= remaining_d;
                        if (remaining_d == '0) begin
                            state_q <= S_DRAIN;
                        end else begin
                            gen_enable_q <= !fifo_prog_full;
                        end
                    end
                    // One cycle for the last generated word to land before reporting done.
                    S_DRAIN: begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                    end
                    S_FINISH: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign gen_pattern   = pattern_q;
    assign gen_reset     = gen_reset_q;
    assign gen_enable    = gen_enable_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_written = words_q;
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_gen_write_controller.sv
// Bench for gen_write_controller: burst-level reference model compared every cycle,
// directed bursts with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_gen_write_controller;

    localparam int CW = 32;
    localparam int PW = 32;

    localparam logic [2:0] P_IDLE  = 3'd0;
    localparam logic [2:0] P_SEED  = 3'd1;
    localparam logic [2:0] P_RUN   = 3'd2;
    localparam logic [2:0] P_DRAIN = 3'd3;
    localparam logic [2:0] P_FIN   = 3'd4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] pattern_in = '0;
    logic [CW-1:0] word_count = '0;
    logic          pf = 1'b0;
    logic          full = 1'b0;
    logic          force_valid = 1'b0;
    logic          gv_pipe = 1'b0;
    logic          gen_valid;
    logic [PW-1:0] gen_pattern;
    logic          gen_reset;
    logic          gen_enable;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_written;
    logic          overflow_err;

    int checks = 0;
    int errors = 0;
    int en_hi_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    assign gen_valid = gv_pipe | force_valid;

    gen_write_controller #(.COUNT_W(CW), .PAT_W(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern_in(pattern_in), .word_count(word_count),
        .fifo_prog_full(pf), .fifo_full(full), .gen_valid(gen_valid),
        .gen_pattern(gen_pattern), .gen_reset(gen_reset), .gen_enable(gen_enable),
        .busy(busy), .done(done), .words_written(words_written), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // Generator stand-in: a word appears the cycle after each enable.
    always @(posedge clk) gv_pipe <= reset ? 1'b0 : gen_enable;

    typedef struct packed {
        logic          live;
        logic [2:0]    ph;
        logic [CW-1:0] len;
        logic [CW-1:0] issued;
        logic [CW-1:0] words;
        logic [PW-1:0] pat;
        logic          en;
        logic          grst;
        logic          done;
        logic          ovf;
        logic          busy;
    } mstate_t;

    mstate_t m = '0;

    // Burst view: a burst owes len strobes; it keeps issuing while fewer than len were issued.
    function automatic mstate_t step(input mstate_t c, input logic rst, input logic st,
                                     input logic ab, input logic [PW-1:0] pin,
                                     input logic [CW-1:0] wc, input logic pf_i,
                                     input logic full_i, input logic gv);
        mstate_t n;
        n = c;
        if (rst) begin
            n = '0;
            n.grst = 1'b1;
            n.live = 1'b1;
            return n;
        end
        n.ovf = c.ovf | (gv & full_i);
        if (c.busy && gv) n.words = c.words + 1;
        n.en = 1'b0;
        n.grst = 1'b0;
        n.done = 1'b0;
        n.issued = c.issued + CW'(c.en);
        if (ab) begin
            n.ph = P_IDLE;
        end else begin
            case (c.ph)
                P_IDLE: if (st) begin
                    n.ph = P_SEED; n.pat = pin; n.len = wc; n.issued = '0;
                    n.words = '0; n.grst = 1'b1; n.ovf = gv & full_i;
                end
                P_SEED: if (c.len == 0) begin n.ph = P_FIN; n.done = 1'b1; end
                        else begin n.ph = P_RUN; n.en = !pf_i; end
                P_RUN: if (n.issued == c.len) n.ph = P_DRAIN; else n.en = !pf_i;
                P_DRAIN: begin n.ph = P_FIN; n.done = 1'b1; end
                default: n.ph = P_IDLE;
            endcase
        end
        n.busy = (n.ph != P_IDLE);
        return n;
    endfunction

    initial forever begin
        @(posedge clk);
        m <= step(m, reset, start, abort, pattern_in, word_count, pf, full, gen_valid);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (m.live) begin
            if (m.ph == P_SEED) begin
                en_hi_cnt = 0; busy_cnt = 0; done_cnt = 0;
            end
            if (gen_enable === 1'b1) en_hi_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            chk("gen_reset", 64'(gen_reset), 64'(m.grst));
            chk("gen_enable", 64'(gen_enable), 64'(m.en));
            chk("busy", 64'(busy), 64'(m.busy));
            chk("done", 64'(done), 64'(m.done));
            chk("words_written", 64'(words_written), 64'(m.words));
            chk("overflow_err", 64'(overflow_err), 64'(m.ovf));
            chk("gen_pattern", 64'(gen_pattern), 64'(m.pat));
            if (m.done) chk("burst_enables", 64'(en_hi_cnt), 64'(m.len));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [PW-1:0] p, input logic [CW-1:0] c);
        pattern_in = p;
        word_count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        pattern_in = $urandom;
        word_count = $urandom;
    endtask

    // Returns at the negedge where done is high (or after the budget expires).
    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for done actual=0 required=1", name);
        end
    endtask

    initial begin
        logic [CW-1:0] w_hold;
        int n;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_gen_reset", 64'(gen_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_words", 64'(words_written), 64'd0);
        chk("rst_pattern", 64'(gen_pattern), 64'd0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_release_gen_reset", 64'(gen_reset), 64'd0);

        // Plain 5-word burst.
        pulse_start(32'd1, 32'd5);
        @(negedge clk);
        chk("t1_gen_reset_pulse", 64'(gen_reset), 64'd1);
        wait_done("t1", 40);
        tick();
        @(negedge clk);
        chk("t1_enables", 64'(en_hi_cnt), 64'd5);
        chk("t1_words", 64'(words_written), 64'd5);
        chk("t1_done_pulses", 64'(done_cnt), 64'd1);
        chk("t1_ovf", 64'(overflow_err), 64'd0);
        chk("t1_pattern", 64'(gen_pattern), 64'd1);
        chk("t1_idle", 64'(busy), 64'd0);

        // Zero-length burst.
        pulse_start(32'd7, 32'd0);
        wait_done("t2", 10);
        tick();
        @(negedge clk);
        chk("t2_enables", 64'(en_hi_cnt), 64'd0);
        chk("t2_busy_cycles", 64'(busy_cnt), 64'd2);
        chk("t2_words", 64'(words_written), 64'd0);
        chk("t2_done_pulses", 64'(done_cnt), 64'd1);

        // Stall on prog_full during RUN cycles 3-7.
        pulse_start(32'd2, 32'd10);
        tick(); tick(); tick();
        pf = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("t3_stalled", 64'(gen_enable), 64'd0);
        tick(); tick(); tick();
        pf = 1'b0;
        wait_done("t3", 60);
        tick();
        @(negedge clk);
        chk("t3_enables", 64'(en_hi_cnt), 64'd10);
        chk("t3_words", 64'(words_written), 64'd10);

        // Abort after 4 of 100 words.
        pulse_start(32'd3, 32'd100);
        n = 0;
        @(negedge clk);
        while (words_written !== 32'd4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reached_4", 64'(words_written), 64'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_enable", 64'(gen_enable), 64'd0);
        chk("t4_words_4_or_5", 64'(words_written == 32'd4 || words_written == 32'd5), 64'd1);
        w_hold = words_written;
        tick(); tick(); tick();
        @(negedge clk);
        chk("t4_words_hold", 64'(words_written), 64'(w_hold));
        chk("t4_no_done", 64'(done_cnt), 64'd0);

        // Overflow: writes land while the FIFO reports full.
        full = 1'b1;
        pulse_start(32'd4, 32'd3);
        wait_done("t5", 30);
        chk("t5_ovf_at_done", 64'(overflow_err), 64'd1);
        tick();
        full = 1'b0;
        tick();
        pulse_start(32'd5, 32'd2);
        @(negedge clk);
        chk("t5_ovf_cleared", 64'(overflow_err), 64'd0);
        wait_done("t5b", 30);
        tick();

        // Start while busy is ignored; start+abort in IDLE is ignored.
        pulse_start(32'd6, 32'd6);
        tick();
        pattern_in = 32'd9;
        word_count = 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6", 40);
        tick();
        @(negedge clk);
        chk("t6_pattern", 64'(gen_pattern), 64'd6);
        chk("t6_enables", 64'(en_hi_cnt), 64'd6);
        chk("t6_done_pulses", 64'(done_cnt), 64'd1);
        pattern_in = 32'd11;
        word_count = 32'd4;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("t6_start_abort_idle", 64'(busy), 64'd0);
        chk("t6_start_abort_pattern", 64'(gen_pattern), 64'd6);
        chk("t6_start_abort_seed", 64'(gen_reset), 64'd0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            start       = ($urandom_range(0, 5) == 0);
            abort       = ($urandom_range(0, 39) == 0);
            pf          = ($urandom_range(0, 3) == 0);
            full        = ($urandom_range(0, 9) == 0);
            force_valid = ($urandom_range(0, 29) == 0);
            pattern_in  = $urandom;
            word_count  = CW'($urandom_range(0, 12));
            tick();
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0; pf = 1'b0; full = 1'b0; force_valid = 1'b0;
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_write_controller.md
GEN_WRITE_CONTROLLER -- requirements
Module: gen_write_controller

Interface
REQ-001 Parameter: COUNT_W, 32, width of word_count, the remaining counter and words_written.
REQ-002 Parameter: PAT_W, 32, width of the pattern selector passed to the generator.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 start  input  1  one-cycle request to begin a burst; honoured only in IDLE.
REQ-006 abort  input  1  terminates any burst; takes priority over start.
REQ-007 pattern_in  input  PAT_W  pattern select; latched on an accepted start.
REQ-008 word_count  input  COUNT_W  burst length in 64-bit words; latched on an accepted start.
REQ-009 fifo_prog_full  input  1  downstream FIFO has 2 or fewer free entries.
REQ-010 fifo_full  input  1  downstream FIFO is full.
REQ-011 gen_valid  input  1  the generator's dataout_available; it is also the FIFO write strobe.
REQ-012 gen_pattern  output  PAT_W  registered pattern select to the generator.
REQ-013 gen_reset  output  1  registered seed/reset strobe to the generator.
REQ-014 gen_enable  output  1  registered generate strobe; one word appears on the cycle after each high cycle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when a burst completes normally.
REQ-017 words_written  output  COUNT_W  count of gen_valid cycles in the current burst.
REQ-018 overflow_err  output  1  sticky flag: gen_valid was seen while fifo_full was high.

Function
REQ-019 The state machine SHALL have the states IDLE, SEED, RUN, DRAIN and FINISH, encoded one-hot or binary.
REQ-020 IDLE->SEED on start=1 and abort=0: latch pattern_in into gen_pattern, latch word_count into remaining, clear words_written, set gen_reset=1 for exactly one cycle.
REQ-021 start SHALL be ignored in every state except IDLE; word_count and pattern_in changes outside the start cycle SHALL have no effect.
REQ-022 SEED->RUN after one cycle; if the latched count is 0, SEED->FINISH and gen_enable never rises.
REQ-023 In RUN, gen_enable(next) SHALL equal !fifo_prog_full && remaining_after_this_cycle>0, where remaining decrements by 1 on each cycle with gen_enable=1.
REQ-024 remaining SHALL never underflow, and the total number of gen_enable high cycles per burst SHALL equal the latched word_count exactly.
REQ-025 RUN->DRAIN on the cycle remaining reaches 0; DRAIN waits one cycle for the final gen_valid, then ->FINISH.
REQ-026 FINISH SHALL pulse done=1 for one cycle and return to IDLE on the next cycle.
REQ-027 words_written SHALL increment on every gen_valid=1 cycle while busy, hold in IDLE, and wrap modulo 2^COUNT_W.
REQ-028 overflow_err SHALL set on any cycle with gen_valid=1 and fifo_full=1, and SHALL clear only on reset or an accepted start.
REQ-029 abort=1 in any state SHALL cause the next state to be IDLE, with gen_enable=0 and gen_reset=0 on the next cycle and no done pulse; words_written holds its value.
REQ-030 If abort and start are high in the same IDLE cycle, the block SHALL stay in IDLE.
REQ-031 gen_pattern SHALL hold its latched value until the next accepted start.

Reset
REQ-032 On reset: state=IDLE, gen_enable=0, gen_reset=1 (holds the generator in reset), done=0, busy=0, words_written=0, overflow_err=0, gen_pattern=0, remaining=0.
REQ-033 gen_reset SHALL return to 0 on the first cycle after reset deasserts; reset asserted mid-burst behaves as REQ-032 on the next edge, regardless of state.

Verification
REQ-034 pattern_in=1, word_count=5, FIFO never full -> gen_reset pulses 1 cycle, gen_enable high exactly 5 consecutive cycles, words_written=5, done pulses once, overflow_err=0.
REQ-035 word_count=0 -> busy high for SEED and FINISH only, gen_enable never high, done pulses, words_written=0.
REQ-036 word_count=10, fifo_prog_full held high for cycles 3-7 of RUN -> gen_enable low during the stall and resumes afterwards, total gen_enable cycles=10, words_written=10.
REQ-037 abort during RUN after 4 words of 100 -> next cycle state=IDLE, gen_enable=0, no done pulse, words_written=4 (or 5 if a word was in flight).
REQ-038 gen_valid forced high with fifo_full=1 -> overflow_err=1 and stays 1 through done; next accepted start clears it.
REQ-039 start re-pulsed while busy, and start+abort together in IDLE -> no new SEED, latched pattern and count unchanged.
